f1_start_controller: RTL and testbench

- Sequencing controller sitting directly downstream of the F1 start-light shift register (8-bit lights: 00→01→03→…→FF→00 on each enable).
- Observes the lights bus and drives the light register's enable.
- Paces the light build-up with a tick prescaler, holds all lights on for a pseudo-random time, releases them, then measures driver reaction time in ticks and flags jump starts.

---
 rtl/f1_start_controller.sv | 82 ++++++++
 tb/tb_f1_start_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/f1_start_controller.sv
// f1_start_controller: paces the F1 start lights via fsm_en, holds for an LFSR-random time, then times the driver's reaction (time_valid/reaction_time) or flags a jump start; busy outside IDLE
module f1_start_controller #(
  parameter int TICK_DIV = 50,
  parameter int TIME_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              react,
  input  logic [7:0]        lights,
  output logic              fsm_en,
  output logic [TIME_W-1:0] reaction_time,
  output logic              time_valid,
  output logic              jump_start,
  output logic              busy
);
  localparam int TW = $clog2(TICK_DIV);
  typedef enum logic [2:0] {IDLE, COUNT, HOLD, REACT, ABORT} state_t;
  state_t            state;
  logic [TW-1:0]     tick_cnt;
  logic [6:0]        hold_cnt;
  logic [6:0]        lfsr;
  logic [TIME_W-1:0] react_cnt;
  logic              tick;
  assign tick = tick_cnt == TW'(TICK_DIV - 1);
  always_comb fsm_en = state == ABORT ? lights != 8'h00 :
                       !react && tick && (state == COUNT ? lights != 8'hff : state == HOLD && hold_cnt == 7'd1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      hold_cnt      <= '0;
      react_cnt     <= '0;
      lfsr          <= 7'h01;
      reaction_time <= '0;
      time_valid    <= 1'b0;
      jump_start    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      lfsr       <= {lfsr[5:0], lfsr[6] ^ lfsr[2]};
      tick_cnt   <= (state == IDLE || tick) ? '0 : tick_cnt + TW'(1);
      time_valid <= 1'b0;
      case (state)
        IDLE: if (trigger) begin
          state      <= COUNT;
          busy       <= 1'b1;
          jump_start <= 1'b0;
        end
        COUNT: if (react) begin
          state      <= ABORT;
          jump_start <= 1'b1;
        end else if (lights == 8'hff) begin
          hold_cnt <= lfsr;
          state    <= HOLD;
        end
        HOLD: if (react) begin
          state      <= ABORT;
          jump_start <= 1'b1;
        end else if (tick) begin
          hold_cnt <= hold_cnt - 7'd1;
          if (hold_cnt == 7'd1) begin
            react_cnt <= '0;
            state     <= REACT;
          end
        end
        REACT: if (react) begin
          reaction_time <= react_cnt;
          time_valid    <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end else if (tick && react_cnt != '1) begin
          react_cnt <= react_cnt + TIME_W'(1);
        end
        ABORT: if (lights == 8'h00) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_f1_start_controller.sv
// tb_f1_start_controller: randomized scenario bench with light-register and reaction-time model for f1_start_controller
module tb_f1_start_controller;
  logic        clk, rst, trigger, react, trigger2, react2;
  logic [7:0]  lights, lights2;
  logic        fsm_en, time_valid, jump_start, busy;
  logic        fsm_en2, tv2, js2, busy2;
  logic [15:0] reaction_time;
  logic [3:0]  rt2;
  int          total, bad, cyc;
  int          seq[127];

  f1_start_controller #(.TICK_DIV(4), .TIME_W(16)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .react(react), .lights(lights),
    .fsm_en(fsm_en), .reaction_time(reaction_time), .time_valid(time_valid),
    .jump_start(jump_start), .busy(busy)
  );

  f1_start_controller #(.TICK_DIV(4), .TIME_W(4)) dut2 (
    .clk(clk), .rst(rst), .trigger(trigger2), .react(react2), .lights(lights2),
    .fsm_en(fsm_en2), .reaction_time(rt2), .time_valid(tv2),
    .jump_start(js2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) lights <= 8'h00;
    else if (fsm_en) lights <= lights == 8'hff ? 8'h00 : {lights[6:0], 1'b1};

  always_ff @(posedge clk or posedge rst)
    if (rst) lights2 <= 8'h00;
    else if (fsm_en2) lights2 <= lights2 == 8'hff ? 8'h00 : {lights2[6:0], 1'b1};

  always_ff @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (fsm_en !== 1'b0 || reaction_time !== 16'h0 || time_valid !== 1'b0 || jump_start !== 1'b0 || busy !== 1'b0 || lights !== 8'h00)
      begin bad++; $display("FAIL reset_outputs en=%b rt=%h tv=%b js=%b busy=%b lights=%h exp all 0", fsm_en, reaction_time, time_valid, jump_start, busy, lights); end
    total++;
    if (rt2 !== 4'h0 || busy2 !== 1'b0 || fsm_en2 !== 1'b0)
      begin bad++; $display("FAIL reset_outputs2 rt=%h busy=%b en=%b exp 0", rt2, busy2, fsm_en2); end
    rst = 1'b0;
    react = 1'b1;
    repeat (3) @(negedge clk);
    react = 1'b0;
    total++;
    if (busy !== 1'b0 || time_valid !== 1'b0 || fsm_en !== 1'b0)
      begin bad++; $display("FAIL idle_react busy=%b tv=%b en=%b exp 0", busy, time_valid, fsm_en); end
  endtask

  task automatic test_sequence(input int d);
    int n, w, l, e;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    total++;
    if (busy !== 1'b1 || jump_start !== 1'b0)
      begin bad++; $display("FAIL seq_start busy=%b js=%b exp 1 0", busy, jump_start); end
    n = 0;
    for (int i = 0; i < 40 && n < 8; i++) begin
      if (fsm_en) begin
        total++;
        if (i != 4 * n + 3 || lights !== 8'((1 << n) - 1))
          begin bad++; $display("FAIL count_pulse n=%0d cyc=%0d lights=%h exp cyc=%0d lights=%h", n, i, lights, 4 * n + 3, 8'((1 << n) - 1)); end
        n++;
      end
      @(negedge clk);
    end
    total++;
    if (n != 8 || lights !== 8'hff)
      begin bad++; $display("FAIL count_done pulses=%0d lights=%h exp 8 ff", n, lights); end
    l = seq[cyc % 127];
    w = 1;
    while (!fsm_en && w < 600) begin @(negedge clk); w++; end
    total++;
    if (w != 4 * l)
      begin bad++; $display("FAIL hold_len got=%0d exp=%0d", w, 4 * l); end
    @(negedge clk);
    total++;
    if (lights !== 8'h00 || busy !== 1'b1)
      begin bad++; $display("FAIL lights_out lights=%h busy=%b exp 00 1", lights, busy); end
    repeat (d) @(negedge clk);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    e = d / 4 > 65535 ? 65535 : d / 4;
    total++;
    if (time_valid !== 1'b1 || reaction_time !== 16'(e) || busy !== 1'b0 || jump_start !== 1'b0)
      begin bad++; $display("FAIL react_capture tv=%b rt=%0d busy=%b js=%b exp 1 %0d 0 0", time_valid, reaction_time, busy, jump_start, e); end
    @(negedge clk);
    total++;
    if (time_valid !== 1'b0 || reaction_time !== 16'(e))
      begin bad++; $display("FAIL react_hold tv=%b rt=%0d exp 0 %0d", time_valid, reaction_time, e); end
  endtask

  task automatic test_jump_count(input int k);
    int w, np, ex;
    logic [7:0] at;
    at = 8'((1 << k) - 1);
    ex = k == 0 ? 0 : 9 - k;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    w = 0;
    while (lights !== at && w < 100) begin @(negedge clk); w++; end
    react = 1'b1;
    total++;
    if (lights !== at || fsm_en !== 1'b0)
      begin bad++; $display("FAIL jump_arm lights=%h en=%b exp %h 0", lights, fsm_en, at); end
    @(negedge clk);
    react = 1'b0;
    np = 0;
    while (fsm_en && np < 20) begin np++; @(negedge clk); end
    total++;
    if (np != ex || lights !== 8'h00)
      begin bad++; $display("FAIL abort_pulses got=%0d lights=%h exp %0d 00", np, lights, ex); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || jump_start !== 1'b1 || time_valid !== 1'b0)
      begin bad++; $display("FAIL abort_end busy=%b js=%b tv=%b exp 0 1 0", busy, jump_start, time_valid); end
  endtask

  task automatic test_jump_hold();
    int w, l, j, np;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    w = 0;
    while (lights !== 8'hff && w < 100) begin @(negedge clk); w++; end
    l = seq[cyc % 127];
    j = $urandom_range(0, 4 * l - 1);
    repeat (j) @(negedge clk);
    react = 1'b1;
    total++;
    if (lights !== 8'hff || fsm_en !== 1'b0)
      begin bad++; $display("FAIL hold_jump_arm lights=%h en=%b exp ff 0 (j=%0d l=%0d)", lights, fsm_en, j, l); end
    @(negedge clk);
    react = 1'b0;
    np = 0;
    while (fsm_en && np < 20) begin np++; @(negedge clk); end
    total++;
    if (np != 1 || lights !== 8'h00)
      begin bad++; $display("FAIL hold_abort_pulses got=%0d lights=%h exp 1 00", np, lights); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || jump_start !== 1'b1)
      begin bad++; $display("FAIL hold_abort_end busy=%b js=%b exp 0 1", busy, jump_start); end
  endtask

  task automatic test_rst_hold();
    int w;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    w = 0;
    while (lights !== 8'hff && w < 100) begin @(negedge clk); w++; end
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b1 || lights !== 8'hff)
      begin bad++; $display("FAIL pre_rst busy=%b lights=%h exp 1 ff", busy, lights); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (fsm_en !== 1'b0 || reaction_time !== 16'h0 || time_valid !== 1'b0 || jump_start !== 1'b0 || busy !== 1'b0 || lights !== 8'h00)
      begin bad++; $display("FAIL async_rst en=%b rt=%h tv=%b js=%b busy=%b lights=%h exp all 0", fsm_en, reaction_time, time_valid, jump_start, busy, lights); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || fsm_en !== 1'b0)
      begin bad++; $display("FAIL post_rst busy=%b en=%b exp 0 0", busy, fsm_en); end
  endtask

  task automatic test_saturate(input int d);
    int w, e;
    trigger2 = 1'b1;
    @(negedge clk);
    trigger2 = 1'b0;
    w = 0;
    while (lights2 !== 8'hff && w < 100) begin @(negedge clk); w++; end
    w = 0;
    while (!fsm_en2 && w < 600) begin @(negedge clk); w++; end
    total++;
    if (fsm_en2 !== 1'b1 || lights2 !== 8'hff)
      begin bad++; $display("FAIL sat_release en=%b lights=%h exp 1 ff", fsm_en2, lights2); end
    @(negedge clk);
    repeat (d) @(negedge clk);
    react2 = 1'b1;
    @(negedge clk);
    react2 = 1'b0;
    e = d / 4 > 15 ? 15 : d / 4;
    total++;
    if (tv2 !== 1'b1 || rt2 !== 4'(e) || busy2 !== 1'b0)
      begin bad++; $display("FAIL sat_capture tv=%b rt=%0d busy=%b exp 1 %0d 0 (d=%0d)", tv2, rt2, busy2, e, d); end
  endtask

  initial begin
    logic [6:0] v;
    total = 0;
    bad = 0;
    rst = 1'b1;
    trigger = 1'b0;
    react = 1'b0;
    trigger2 = 1'b0;
    react2 = 1'b0;
    v = 7'h01;
    for (int i = 0; i < 127; i++) begin
      seq[i] = int'(v);
      v = {v[5:0], v[6] ^ v[2]};
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_sequence(40);
    test_jump_count(3);
    test_sequence($urandom_range(0, 200));
    test_jump_count($urandom_range(0, 8));
    test_jump_count(8);
    test_sequence($urandom_range(0, 7));
    test_jump_count(0);
    test_sequence(44);
    test_jump_hold();
    test_rst_hold();
    test_sequence($urandom_range(0, 120));
    test_jump_hold();
    test_saturate(80);
    test_saturate($urandom_range(0, 59));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
